// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external combinational ALU between two valid/ready requesters.
// Latency: accept edge -> one EXEC cycle -> rsp_valid raised on the following edge; 3 cycles per op minimum.
// Backpressure: response held until rsp_ready of the granted requester; no new accept outside IDLE.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [5:0]         req_op,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_zero,
    output logic [WIDTH-1:0]   alu_srca,
    output logic [WIDTH-1:0]   alu_srcb,
    output logic [2:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   alu_srca_q, alu_srca_d;
    logic [WIDTH-1:0]   alu_srcb_q, alu_srcb_d;
    logic [2:0]         alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic               win;
    logic               any_req;

    always_comb begin
        any_req = |req_valid;
        // Contention goes to whoever was not served last; a sole requester always wins.
        win     = (&req_valid) ? ~last_grant_q : req_valid[1];

        req_ready = 2'b00;
        if (rst_n && (state_q == IDLE) && any_req) begin
            req_ready = 2'b01 << win;
        end

        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        alu_srca_d   = alu_srca_q;
        alu_srcb_d   = alu_srcb_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_valid_d  = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d    = win;
                    alu_srca_d = win ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
                    alu_srcb_d = win ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
                    alu_ctrl_d = win ? req_op[5:3] : req_op[2:0];
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_result;
                rsp_zero_d  = alu_zero;
                rsp_valid_d = 2'b01 << grant_q;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    rsp_valid_d  = 2'b00;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_srca_q   <= '0;
            alu_srcb_q   <= '0;
            alu_ctrl_q   <= 3'b000;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_valid_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            alu_srca_q   <= alu_srca_d;
            alu_srcb_q   <= alu_srcb_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign alu_srca  = alu_srca_q;
    assign alu_srcb  = alu_srcb_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached to the alu_* ports.
module tb_alu_share_arbiter;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [5:0]     req_op;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_zero;
    logic [W-1:0]   alu_srca;
    logic [W-1:0]   alu_srcb;
    logic [2:0]     alu_ctrl;
    logic [W-1:0]   alu_result;
    logic           alu_zero;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_srca & alu_srcb;
            3'b001:  alu_result = alu_srca | alu_srcb;
            3'b010:  alu_result = alu_srca + alu_srcb;
            3'b110:  alu_result = alu_srca - alu_srcb;
            3'b111:  alu_result = {{(W-1){1'b0}}, ($signed(alu_srca) < $signed(alu_srcb))};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transaction from requester idx with rsp_ready held high; inputs driven at a negedge.
    task automatic run_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op, input logic [W-1:0] exp_d, input logic exp_z);
        logic [1:0] oh;
        oh = (idx == 0) ? 2'b01 : 2'b10;
        rsp_ready = 2'b11;
        req_a = '0; req_b = '0; req_op = '0;
        if (idx == 0) begin
            req_a[0 +: W] = a; req_b[0 +: W] = b; req_op[2:0] = op;
        end else begin
            req_a[W +: W] = a; req_b[W +: W] = b; req_op[5:3] = op;
        end
        req_valid = oh;
        #1 chk("single_req_ready", req_ready, oh);
        next_neg();
        chk("exec_busy", busy, 1);
        chk("exec_no_rsp", rsp_valid, 0);
        chk("exec_srca", alu_srca, a);
        chk("exec_ctrl", alu_ctrl, op);
        req_valid = 2'b00;
        req_a = '1;
        next_neg();
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_zero", rsp_zero, exp_z);
        next_neg();
        chk("rsp_done", rsp_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = {32'd11, 32'd22};
        req_b     = {32'd33, 32'd44};
        req_op    = 6'b010_010;
        rsp_ready = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_srca", alu_srca, 0);
        chk("rst_srcb", alu_srcb, 0);
        chk("rst_ctrl", alu_ctrl, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1 chk("first_grant_0", req_ready, 2'b01);

        run_one(0, 32'd7, 32'd5, 3'b010, 32'd12, 1'b0);
        run_one(1, 32'd9, 32'd9, 3'b110, 32'd0, 1'b1);
        run_one(1, 32'd3, 32'd8, 3'b111, 32'd1, 1'b0);

        // Contention: last served was requester 1, so grants go 0,1,0,1...
        rsp_ready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            logic [1:0]   exp_oh;
            logic [W-1:0] exp_d;
            req_a  = {32'h0000_0100 * (k + 1), 32'h0000_0001 * (k + 1)};
            req_b  = {32'h0010_0000 * (k + 1), 32'h0000_1000 * (k + 1)};
            req_op = 6'b001_001;
            req_valid = 2'b11;
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d  = (k % 2 == 0) ? ((32'h1 * (k + 1)) | (32'h1000 * (k + 1)))
                                  : ((32'h100 * (k + 1)) | (32'h10_0000 * (k + 1)));
            #1 chk("rr_grant", req_ready, exp_oh);
            next_neg();
            req_a = '1;
            req_b = '1;
            req_op = 6'b000_000;
            next_neg();
            chk("rr_rsp_valid", rsp_valid, exp_oh);
            chk("rr_rsp_data", rsp_data, exp_d);
            next_neg();
        end

        // Backpressure: requester 0 adds 3+4, response stalls 5 cycles.
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_a = {32'd100, 32'd3};
        req_b = {32'd200, 32'd4};
        req_op = 6'b010_010;
        req_valid = 2'b01;
        next_neg();
        req_valid = 2'b11;
        next_neg();
        for (int k = 0; k < 5; k++) begin
            rsp_ready = (k == 2) ? 2'b10 : 2'b00;
            chk("bp_rsp_valid", rsp_valid, 2'b01);
            chk("bp_rsp_data", rsp_data, 32'd7);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_busy", busy, 1);
            next_neg();
        end
        chk("bp_still_held", rsp_valid, 2'b01);
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        next_neg();
        chk("bp_released", rsp_valid, 0);
        chk("bp_idle", busy, 0);

        // Mid-operation reset while in EXEC.
        req_a = {32'd5, 32'd0};
        req_b = {32'd6, 32'd0};
        req_op = 6'b010_000;
        req_valid = 2'b10;
        next_neg();
        chk("mid_exec_busy", busy, 1);
        chk("mid_exec_srca", alu_srca, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_srca", alu_srca, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_neg();
            chk("post_rst_no_rsp", rsp_valid, 0);
        end
        req_valid = 2'b11;
        #1 chk("post_rst_grant_0", req_ready, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
